// File: rtl/seq_div_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : seq_div_pkg
//  Description : Shared types and helpers for the sequential signed divider:
//                FSM state encoding, step-counter width and quotient
//                saturation limits.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_div_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    // Width of a counter that can hold 0..2W
    function automatic int step_cnt_width(input int w);
        return $clog2(2 * w + 1);
    endfunction

    // Largest signed W-bit quotient
    function automatic int q_max(input int w);
        return (2 ** (w - 1)) - 1;
    endfunction

    // Smallest signed W-bit quotient
    function automatic int q_min(input int w);
        return -(2 ** (w - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_signed_divider_if.sv
`default_nettype none
// ============================================================================
//  Interface   : seq_signed_divider_if
//  Description : Start/busy/done operand and result bundle of the sequential
//                signed divider. master = requester, slave = divider.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_signed_divider_if #(
    parameter int W = 4
);
    logic               start;
    logic [2*W-1:0]     dividend;
    logic [W-1:0]       divisor;
    logic [W-1:0]       quotient;
    logic [W-1:0]       remainder;
    logic               busy;
    logic               done;
    logic               dbz;
    logic               ovf;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, dbz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, dbz, ovf
    );
endinterface
`default_nettype wire

// File: rtl/seq_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : seq_div_step
//  Description : One unsigned restoring division slice: shift the partial
//                remainder left, append the next dividend bit, subtract the
//                divisor when it fits and emit the quotient bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_div_step #(
    parameter int W = 4
) (
    input  wire logic [W-1:0] i_rem,
    input  wire logic         i_bit,
    input  wire logic [W-1:0] i_dvs,
    output logic      [W-1:0] o_rem,
    output logic              o_qbit
);

    logic [W:0] w_shift;

    // Shift/compare/subtract; the result is always below the divisor so W bits hold it
    always_comb begin
        w_shift = {i_rem, i_bit};
        o_qbit  = (w_shift >= {1'b0, i_dvs});
        o_rem   = W'(o_qbit ? (w_shift - {1'b0, i_dvs}) : w_shift);
    end

endmodule
`default_nettype wire

// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_signed_divider
//  Description : Multi-cycle signed divider. 2W-bit dividend / W-bit divisor
//                -> W-bit quotient (truncated toward zero) and W-bit remainder
//                (sign of dividend), one restoring step per clock.
//                Optional macro SEQ_DIV_OVF_SAT_EN: flag quotient overflow and
//                saturate the quotient; otherwise the quotient wraps, ovf = 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_signed_divider
    import seq_div_pkg::*;
#(
    parameter int W = 4
) (
    input  wire logic           clk,
    input  wire logic           reset_n,
    seq_signed_divider_if.slave bus
);

    localparam int c_CNT_W = step_cnt_width(W);

`ifdef SEQ_DIV_OVF_SAT_EN
    localparam logic [W-1:0] c_QMAX = W'(q_max(W));
    localparam logic [W-1:0] c_QMIN = W'(q_min(W));
`endif

    state_t               r_state;
    state_t               w_state_nxt;

    logic [2*W-1:0]       r_dvd;
    logic [W-1:0]         r_dvs;
    logic [W-1:0]         r_dvs_mag;
    logic [2*W-1:0]       r_quo;
    logic [W-1:0]         r_rem;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [W-1:0]         r_quotient;
    logic [W-1:0]         r_remainder;
    logic                 r_done;
    logic                 r_dbz;
    logic                 r_ovf;

    logic                 w_neg_dvd;
    logic                 w_neg_q;
    logic                 w_dvs_zero;
    logic                 w_last;
    logic [W-1:0]         w_rem_nxt;
    logic                 w_qbit;
    logic [W-1:0]         w_q_fix;
    logic [W-1:0]         w_r_fix;
    logic                 w_ovf;
`ifdef SEQ_DIV_OVF_SAT_EN
    logic [2*W:0]         w_q_signed;
`endif

    assign w_neg_dvd  = r_dvd[2*W-1];
    assign w_neg_q    = r_dvd[2*W-1] ^ r_dvs[W-1];
    assign w_dvs_zero = (r_dvs == '0);
    assign w_last     = (r_cnt == c_CNT_W'(2 * W - 1));

    seq_div_step #(
        .W      (W)
    ) u_step (
        .i_rem  (r_rem),
        .i_bit  (r_quo[2*W-1]),
        .i_dvs  (r_dvs_mag),
        .o_rem  (w_rem_nxt),
        .o_qbit (w_qbit)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = w_dvs_zero ? S_IDLE : S_ITER;
            S_ITER:  if (w_last) w_state_nxt = S_FIX;
            S_FIX:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, magnitude formation and the shift-subtract iteration.
    // The 2W-bit two's-complement negation read as unsigned is the exact
    // magnitude, since no magnitude exceeds 2^(2W-1) (or 2^(W-1) for the divisor).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_dvs_mag <= '0;
            r_quo     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_dvd <= bus.dividend;
                        r_dvs <= bus.divisor;
                    end
                end
                S_LOAD: begin
                    r_quo     <= w_neg_dvd ? -r_dvd : r_dvd;
                    r_dvs_mag <= r_dvs[W-1] ? -r_dvs : r_dvs;
                    r_rem     <= '0;
                    r_cnt     <= '0;
                end
                S_ITER: begin
                    r_quo <= {r_quo[2*W-2:0], w_qbit};
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sign correction and overflow handling of the magnitude result
    always_comb begin
        w_r_fix = w_neg_dvd ? -r_rem : r_rem;
`ifdef SEQ_DIV_OVF_SAT_EN
        w_q_signed = w_neg_q ? -{1'b0, r_quo} : {1'b0, r_quo};
        w_ovf      = ($signed(w_q_signed) > q_max(W)) || ($signed(w_q_signed) < q_min(W));
        w_q_fix    = w_ovf ? (w_neg_q ? c_QMIN : c_QMAX) : w_q_signed[W-1:0];
`else
        w_ovf      = 1'b0;
        w_q_fix    = W'(w_neg_q ? -r_quo : r_quo);
`endif
    end

    // Result registers and the one-cycle done pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if ((r_state == S_LOAD) && w_dvs_zero) begin
                r_quotient  <= '1;
                r_remainder <= r_dvd[W-1:0];
                r_dbz       <= 1'b1;
                r_ovf       <= 1'b0;
                r_done      <= 1'b1;
            end else if (r_state == S_FIX) begin
                r_quotient  <= w_q_fix;
                r_remainder <= w_r_fix;
                r_dbz       <= 1'b0;
                r_ovf       <= w_ovf;
                r_done      <= 1'b1;
            end
        end
    end

    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.done      = r_done;
    assign bus.dbz       = r_dbz;
    assign bus.ovf       = r_ovf;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
